mul_const_11_recon: RTL
=======================

// Module: mul_const_11_recon
// PURPOSE
//   Inverse of the 16-bit divide-by-11 datapath: rebuilds the dividend as X = Q*11 + R
//   from a quotient/remainder pair. Digit-serial: Horner MSB-first over 4-bit quotient
//   digits, so the constant multiply is a shift-add network, not a full multiplier.
//   Consumed by the divider self-check path and by the model-vs-RTL scoreboards.
// PARAMETERS
//   WIDTH       16  quotient width in bits; must be a multiple of DIGIT_BITS
//   DIVISOR     11  constant multiplier; also the legal remainder bound (R < DIVISOR)
//   DIGIT_BITS   4  quotient bits consumed per RUN cycle
//   (localparam RW = $clog2(DIVISOR) = 4 remainder width; XW = WIDTH+RW = 20 result width)
// PORTS
//   clk        in   1      clock; all state changes on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      quotient/remainder pair offered
//   in_ready   out  1      block can accept a pair (high only in IDLE)
//   in_q       in   WIDTH  quotient Q
//   in_r       in   RW     remainder R
//   out_valid  out  1      result X valid
//   out_ready  in   1      sink accepts X
//   out_x      out  XW     X = Q*DIVISOR + R, modulo 2^XW
//   out_err    out  1      R >= DIVISOR was presented with this pair
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, acc=0, digit count=0, out_valid=0, out_x=0,
//     out_err=0, in_ready=1 from the next cycle. Reset mid-RUN or in DONE discards the
//     operation with no output; reset wins over every simultaneous handshake.
//   FSM states IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch in_q, in_r; acc<=0; cnt<=0;
//     err<=(in_r>=DIVISOR); go to RUN. Inputs are ignored outside this cycle.
//   RUN: in_ready=0. Each cycle: d = Q[WIDTH-1-cnt*DIGIT_BITS -: DIGIT_BITS];
//     acc <= (acc<<DIGIT_BITS) + d*DIVISOR (d*11 = (d<<3)+(d<<1)+d); cnt++.
//     On the last digit (cnt==WIDTH/DIGIT_BITS-1) add R in the same cycle, go to DONE.
//   DONE: out_valid=1, out_x=acc, out_err=err, held stable until out_ready=1.
//     out_valid&&out_ready -> IDLE; no new pair is accepted in that same cycle.
//   Latency: accept edge at cycle 0; RUN spans cycles 1..WIDTH/DIGIT_BITS (4);
//     out_valid first high in cycle 5. Throughput: 1 pair / 6 cycles with out_ready=1.
//   Width rule: acc is XW bits; for R<DIVISOR the result never overflows
//     (max 65535*11+10 = 720895 < 2^20). With out_err=1 the sum is still formed as
//     Q*DIVISOR+R, truncated to XW bits; no saturation.
//   Q=0 still takes the full RUN length (no early exit). R is zero-extended into acc.
//   All outputs are registered or decoded from state only; no input->output comb path.
// TESTING
//   Q=0, R=0 -> out_valid in cycle 5, out_x=0, out_err=0; in_ready returns high next cycle.
//   Q=0xFFFF, R=10 -> out_x=720895 (0xAFFFF), out_err=0.
//   Q=1234, R=5 -> out_x=13579; Q=1234, R=11 -> out_x=13585, out_err=1.
//   Backpressure: out_ready=0 for 7 cycles after out_valid -> out_x/out_err stable, in_ready=0
//     throughout; in_valid held high meanwhile is not accepted until IDLE.
//   Reset asserted in RUN cycle 2 -> no out_valid; next pair Q=7,R=3 -> out_x=80.
//   Random sweep: 10k pairs, R in 0..15, random out_ready -> out_x==(Q*11+R) mod 2^20,
//     out_err==(R>=11), one result per accepted pair, in order.

Source files
------------

// File: rtl/mul_const_11_recon.sv
// Rebuilds X = Q*DIVISOR + R from a quotient/remainder pair, digit-serial MSB-first (Horner),
// using a shift-add constant multiply per quotient digit.
module mul_const_11_recon #(
   parameter  int unsigned WIDTH      = 16,
   parameter  int unsigned DIVISOR    = 11,
   parameter  int unsigned DIGIT_BITS = 4,
   localparam int unsigned RW         = $clog2(DIVISOR),
   localparam int unsigned XW         = WIDTH + RW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WIDTH-1:0] in_q,
   input  logic [RW-1:0] in_r,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [XW-1:0] out_x,
   output logic          out_err
);

   localparam int unsigned NDIG = WIDTH / DIGIT_BITS;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned DW   = $clog2(DIVISOR + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [XW-1:0]        acc_q, acc_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [RW-1:0]        r_q, r_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [DIGIT_BITS-1:0] digit;
   logic [XW-1:0]        prod;
   logic                 last;

   // Quotient is shifted left each RUN cycle so the current digit always sits at the top.
   assign digit = q_q[WIDTH-1 -: DIGIT_BITS];
   assign last  = (cnt_q == CW'(NDIG - 1));

   // Constant multiply digit*DIVISOR as a sum of shifted copies, one per set divisor bit.
   always_comb begin
      prod = '0;
      for (int unsigned i = 0; i < DW; i++) begin
         if (((DIVISOR >> i) & 32'd1) != 32'd0) begin
            prod = prod + (XW'(digit) << i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               q_d     = in_q;
               r_d     = in_r;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = (32'(in_r) >= DIVISOR);
               state_d = RUN;
            end
         end
         RUN: begin
            // Remainder folds in on the final digit, zero-extended.
            acc_d = (acc_q << DIGIT_BITS) + prod + (last ? XW'(r_q) : '0);
            q_d   = q_q << DIGIT_BITS;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_x     = acc_q;
   assign out_err   = err_q;

endmodule
